// File: rtl/apb_pkg.sv
// Shared APB definitions used by the bridge and the interconnect.
// Contents: bus state enumeration, default address/data widths, default
// timeout, and the wait-counter width (wide enough for TIMEOUT up to 255).
package apb_pkg;

  localparam int APB_ADDR_W  = 12;
  localparam int APB_DATA_W  = 32;
  localparam int APB_TIMEOUT = 16;
  localparam int APB_CTR_W   = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_timeout_ctr.sv
// Purpose: ACCESS-phase wait counter; expired is high while the count equals TIMEOUT-1.
// Latency: expired decodes the registered count, so it reflects the current cycle.
// Backpressure: none; clear has priority over enable.
// Ports: clk, rst (sync active-low), clear, enable, expired.
module apb_timeout_ctr
  import apb_pkg::*;
#(
  parameter int TIMEOUT = APB_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [APB_CTR_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + APB_CTR_W'(1);
    end
  end

  assign expired = (count == APB_CTR_W'(TIMEOUT - 1));

endmodule

// File: rtl/apb_master_bridge.sv
// Purpose: single-outstanding valid/ready request to APB master (IDLE/SETUP/ACCESS).
// Latency: handshake -> SETUP +1, ACCESS +2, rsp_valid pulse +3 minimum; TIMEOUT caps ACCESS length.
// Backpressure: req_ready is high only in IDLE; requests outside IDLE are ignored, never queued.
// Ports: clk, rst (sync active-low); req_valid/req_ready/req_write/req_addr/req_wdata;
//        rsp_valid/rsp_rdata/rsp_err; addr_out/wr_out/sel_out/enable_out/data_out to
//        the interconnect; ready_in/rdata_in/slverr_in from the slave. TIMEOUT must be 2..255.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = APB_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] addr_out,
  output logic              wr_out,
  output logic              sel_out,
  output logic              enable_out,
  output logic [DATA_W-1:0] data_out,
  input  logic              ready_in,
  input  logic [DATA_W-1:0] rdata_in,
  input  logic              slverr_in
);

  apb_state_e        state, state_d;
  logic              req_ready_d, rsp_valid_d, rsp_err_d;
  logic              wr_d, sel_d, en_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d, rdata_d;
  logic              expired, ctr_clear, ctr_en;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      addr_out   <= '0;
      wr_out     <= 1'b0;
      sel_out    <= 1'b0;
      enable_out <= 1'b0;
      data_out   <= '0;
    end else begin
      state      <= state_d;
      req_ready  <= req_ready_d;
      rsp_valid  <= rsp_valid_d;
      rsp_rdata  <= rdata_d;
      rsp_err    <= rsp_err_d;
      addr_out   <= addr_d;
      wr_out     <= wr_d;
      sel_out    <= sel_d;
      enable_out <= en_d;
      data_out   <= data_d;
    end
  end

  always_comb begin
    state_d     = state;
    addr_d      = addr_out;
    wr_d        = wr_out;
    data_d      = data_out;
    sel_d       = sel_out;
    en_d        = enable_out;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err;
    rdata_d     = rsp_rdata;

    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          state_d = SETUP;
          addr_d  = req_addr;
          wr_d    = req_write;
          data_d  = req_wdata;
          sel_d   = 1'b1;
          en_d    = 1'b0;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        en_d    = 1'b1;
      end
      ACCESS: begin
        // ready_in is checked first so a response on the last allowed
        // cycle completes normally instead of timing out.
        if (ready_in || expired) begin
          state_d     = IDLE;
          sel_d       = 1'b0;
          en_d        = 1'b0;
          wr_d        = 1'b0;
          rsp_valid_d = 1'b1;
          if (ready_in) begin
            rsp_err_d = slverr_in;
            rdata_d   = wr_out ? '0 : rdata_in;
          end else begin
            rsp_err_d = 1'b1;
            rdata_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = 1'b0;
        en_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase

    // Registered so req_ready is already high in the rsp_valid cycle.
    req_ready_d = (state_d == IDLE);
  end

  // Count only ACCESS cycles; clearing on any non-ACCESS next state makes
  // the first ACCESS cycle start from zero.
  assign ctr_clear = (state_d != ACCESS);
  assign ctr_en    = (state == ACCESS);

  apb_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_ctr (
    .clk    (clk),
    .rst    (rst),
    .clear  (ctr_clear),
    .enable (ctr_en),
    .expired(expired)
  );

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed scenarios plus randomized transfers.
// A driver issues requests and plays the slave; a negedge monitor checks
// responses and bus phases against expectations queued at issue time.
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] addr_out;
  logic          wr_out, sel_out, enable_out;
  logic [DW-1:0] data_out;
  logic          ready_in = 1'b0, slverr_in = 1'b0;
  logic [DW-1:0] rdata_in = '0;

  always #5 clk = ~clk;

  apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .addr_out(addr_out), .wr_out(wr_out), .sel_out(sel_out),
    .enable_out(enable_out), .data_out(data_out),
    .ready_in(ready_in), .rdata_in(rdata_in), .slverr_in(slverr_in)
  );

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          err;
    logic [DW-1:0] rdata;
    int            access;
  } exp_t;

  exp_t        expq[$];
  int unsigned hsq[$];
  int unsigned cyc = 0;
  int          checks = 0, errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: slave answers after `waits` wait cycles; if that exceeds the
  // TIMEOUT-cycle ACCESS budget the bridge gives up with an error.
  function automatic exp_t model(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                 input int waits, input logic serr, input logic [DW-1:0] rd);
    exp_t e;
    e.wr = wr; e.addr = a; e.wdata = d;
    if (waits < TO) begin
      e.err = serr; e.rdata = wr ? '0 : rd; e.access = waits + 1;
    end else begin
      e.err = 1'b1; e.rdata = '0; e.access = TO;
    end
    return e;
  endfunction

  // Monitor
  int setup_n = 0, acc_n = 0;
  bit bad = 1'b0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst && req_valid && req_ready) hsq.push_back(cyc);
    if (rsp_valid === 1'b1) begin
      if (expq.size() == 0) begin
        chk("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        e = expq.pop_front();
        chk("rsp_err", 64'(rsp_err), 64'(e.err));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        chk("setup_cycles", 64'(setup_n), 64'd1);
        chk("access_cycles", 64'(acc_n), 64'(e.access));
        chk("bus_stable", 64'(bad), 64'd0);
        chk("idle_ctrl", 64'({sel_out, enable_out, wr_out, req_ready}), 64'b0001);
        chk("idle_addr_hold", 64'(addr_out), 64'(e.addr));
        chk("idle_data_hold", 64'(data_out), 64'(e.wdata));
      end
      setup_n = 0; acc_n = 0; bad = 1'b0;
    end else if (sel_out !== 1'b1) begin
      setup_n = 0; acc_n = 0; bad = 1'b0;
    end else begin
      if (expq.size() == 0) bad = 1'b1;
      else if (addr_out !== expq[0].addr || data_out !== expq[0].wdata || wr_out !== expq[0].wr)
        bad = 1'b1;
      if (enable_out !== 1'b1) begin
        setup_n++;
        if (acc_n != 0) bad = 1'b1;
      end else begin
        acc_n++;
      end
    end
  end

  task automatic idle_garbage();
    ready_in  = 1'($urandom_range(0, 1));
    slverr_in = 1'($urandom_range(0, 1));
    rdata_in  = DW'($urandom);
  endtask

  // One transfer; abort_at >= 0 pulls reset in that ACCESS cycle instead.
  task automatic xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input int waits, input logic serr, input logic [DW-1:0] rd, input int abort_at);
    int guard = 0;
    while (req_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if (req_ready !== 1'b1) begin
      chk("req_ready_wait", 64'd0, 64'd1);
      return;
    end
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    if (abort_at < 0) expq.push_back(model(wr, a, d, waits, serr, rd));
    @(posedge clk); #1;
    // SETUP: request and slave inputs are noise that must be ignored
    req_valid = (abort_at < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    req_write = 1'($urandom_range(0, 1));
    req_addr  = AW'($urandom);
    req_wdata = DW'($urandom);
    idle_garbage();
    @(posedge clk); #1;
    for (int k = 0; k < 300; k++) begin
      if (k == abort_at) begin
        rst = 1'b0; ready_in = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("abort_ctrl", 64'({req_ready, rsp_valid, sel_out, enable_out, wr_out, rsp_err}), 64'b100000);
        chk("abort_addr", 64'(addr_out), 64'd0);
        chk("abort_data", 64'(data_out), 64'd0);
        chk("abort_rdata", 64'(rsp_rdata), 64'd0);
        return;
      end
      ready_in  = (k == waits);
      rdata_in  = (k == waits) ? rd : DW'($urandom);
      slverr_in = (k == waits) ? serr : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (k == waits || k == TO - 1) break;
    end
    req_valid = 1'b0;
    idle_garbage();
  endtask

  task automatic b2b();
    int guard = 0;
    hsq.delete();
    while (req_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    ready_in = 1'b1; slverr_in = 1'b0; rdata_in = DW'($urandom);
    expq.push_back(model(1'b1, AW'(0), DW'(4), 0, 1'b0, '0));
    expq.push_back(model(1'b1, AW'('h600), DW'(6), 0, 1'b0, '0));
    req_valid = 1'b1; req_write = 1'b1; req_addr = AW'(0); req_wdata = DW'(4);
    @(posedge clk); #1;
    req_addr = AW'('h600); req_wdata = DW'(6);
    for (int i = 0; i < 10 && hsq.size() < 2; i++) begin
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (hsq.size() >= 2) chk("b2b_gap", 64'(hsq[1] - hsq[0]), 64'd3);
    else chk("b2b_second_handshake", 64'd0, 64'd1);
    repeat (2) @(posedge clk);
    #1;
    ready_in = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", 64'({req_ready, rsp_valid, sel_out, enable_out, wr_out, rsp_err}), 64'b100000);
    chk("reset_addr", 64'(addr_out), 64'd0);
    chk("reset_data", 64'(data_out), 64'd0);
    chk("reset_rdata", 64'(rsp_rdata), 64'd0);
    rst = 1'b1;

    xfer(1'b1, AW'('h300), DW'(13), 0, 1'b0, '0, -1);              // plain write
    xfer(1'b0, AW'('h500), '0, 3, 1'b0, DW'('hDEADBEEF), -1);      // read, 3 waits
    xfer(1'b1, AW'('h400), DW'($urandom), 100, 1'b0, '0, -1);      // timeout
    xfer(1'b0, AW'('h000), '0, 0, 1'b1, DW'($urandom), -1);        // slave error
    xfer(1'b0, AW'('h123), '0, TO - 1, 1'b0, DW'('hCAFE), -1);     // ready on last cycle
    xfer(1'b0, AW'('h124), '0, TO, 1'b0, DW'('hBEEF), -1);         // one too late
    b2b();
    xfer(1'b0, AW'('h7a0), '0, 20, 1'b0, '0, 1);                   // reset abort
    xfer(1'b1, AW'('h0ab), DW'('h55), 1, 1'b0, '0, -1);            // first edge after reset

    for (int n = 0; n < 40; n++) begin
      int r, w;
      r = $urandom_range(0, 9);
      w = (r < 6) ? $urandom_range(0, 4) : ((r < 8) ? $urandom_range(TO - 2, TO) : $urandom_range(0, TO + 3));
      xfer(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), w,
           1'($urandom_range(0, 1)), DW'($urandom), -1);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("drain_pending", 64'(expq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning the address width matching the interconnect addr_in.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the data width matching the interconnect data_in.
REQ-003 SHALL have parameter TIMEOUT, default 16, meaning the maximum ACCESS cycles before forced error termination (range 2..255).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port req_valid, input, 1 bit: the requester presents a transfer.
REQ-007 SHALL have port req_ready, output, 1 bit: the bridge accepts the transfer this cycle.
REQ-008 SHALL have port req_write, input, 1 bit: 1 selects write, 0 selects read.
REQ-009 SHALL have port req_addr, input, ADDR_W bits: the transfer address.
REQ-010 SHALL have port req_wdata, input, DATA_W bits: the write data.
REQ-011 SHALL have port rsp_valid, output, 1 bit: a one-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata, output, DATA_W bits: the read data, valid with rsp_valid.
REQ-013 SHALL have port rsp_err, output, 1 bit: slave error or timeout, valid with rsp_valid.
REQ-014 SHALL have port addr_out, output, ADDR_W bits: drives interconnect addr_in.
REQ-015 SHALL have port wr_out, output, 1 bit: drives interconnect wr_in.
REQ-016 SHALL have port sel_out, output, 1 bit: drives interconnect sel.
REQ-017 SHALL have port enable_out, output, 1 bit: APB enable phase.
REQ-018 SHALL have port data_out, output, DATA_W bits: drives interconnect data_in.
REQ-019 SHALL have port ready_in, input, 1 bit: slave ready returned through the interconnect.
REQ-020 SHALL have port rdata_in, input, DATA_W bits: slave read data.
REQ-021 SHALL have port slverr_in, input, 1 bit: slave error, sampled only when ready_in is high.

Function
REQ-022 SHALL implement the FSM states IDLE, SETUP and ACCESS, with all outputs registered.
REQ-023 SHALL drive req_ready high only in IDLE; a handshake occurs when req_valid and req_ready are both high.
REQ-024 On a handshake SHALL latch addr, write and wdata into addr_out, wr_out and data_out, and go to SETUP the next cycle with sel_out=1 and enable_out=0.
REQ-025 SETUP SHALL last exactly one cycle and then go to ACCESS with sel_out=1 and enable_out=1.
REQ-026 addr_out, wr_out and data_out SHALL be stable from SETUP through the final ACCESS cycle.
REQ-027 In ACCESS with ready_in=1, SHALL go to IDLE with sel_out=0 and enable_out=0 on the next cycle.
REQ-028 On that same next cycle SHALL pulse rsp_valid=1 with rsp_err=slverr_in and rsp_rdata=rdata_in when the transfer is a read, or 0 when it is a write.
REQ-029 ACCESS SHALL hold while ready_in=0, with a wait counter incrementing from 0.
REQ-030 When the wait counter reaches TIMEOUT-1 with ready_in=0, SHALL terminate like REQ-027/REQ-028 with rsp_err=1 and rsp_rdata=0.
REQ-031 If ready_in=1 on the TIMEOUT-1 cycle, SHALL treat the transfer as a normal completion (ready_in wins).
REQ-032 req_ready SHALL be 1 in the same cycle rsp_valid pulses, because the state is IDLE, so a transfer takes a minimum of 3 cycles from handshake to handshake.
REQ-033 SHALL ignore ready_in, rdata_in and slverr_in outside ACCESS.
REQ-034 SHALL ignore req_* inputs outside IDLE, with no queuing.
REQ-035 addr_out and data_out SHALL retain their last values in IDLE, while wr_out SHALL clear to 0.

Reset
REQ-036 When rst=0 at a clock edge, SHALL go to IDLE and set req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, addr_out=0, wr_out=0, sel_out=0, enable_out=0, data_out=0, and wait counter=0.
REQ-037 Reset during SETUP or ACCESS SHALL abort the transfer without any rsp_valid pulse, and the bus SHALL be idle on the first post-reset cycle.
REQ-038 A handshake SHALL be accepted on the first edge with rst=1.

Structure
REQ-039 SHALL declare the state enum (IDLE, SETUP, ACCESS) and the default widths in a shared package apb_pkg, which the interconnect also imports.
REQ-040 SHALL implement the wait counter as a sub-module apb_timeout_ctr (inputs: clear, enable; output: expired at TIMEOUT-1).
REQ-041 The bridge SHALL otherwise be a single flat module.

Verification
REQ-042 Write test: write to 0x300 with data 13 and ready_in tied to 1 -> SETUP at cycle+1 (sel=1, en=0), ACCESS at cycle+2 (en=1), rsp_valid at cycle+3 with err=0.
REQ-043 Read test: read from 0x500 with ready_in low for 3 ACCESS cycles and rdata_in=0xDEADBEEF -> addr_out stable for 5 cycles, then rsp_rdata=0xDEADBEEF and rsp_err=0.
REQ-044 Timeout test: write to 0x400 with ready_in held at 0 and TIMEOUT=16 -> exactly 16 ACCESS cycles, then rsp_valid=1 with rsp_err=1 and the bus returns to idle.
REQ-045 Slave-error test: read from 0x000 with ready_in=1 and slverr_in=1 -> rsp_err=1 and the bus returns to idle.
REQ-046 Back-to-back test: req_valid held high with two writes (0x000 data 4, then 0x600 data 6) -> the second handshake occurs on the rsp_valid cycle of the first, with 3 cycles between handshakes.
REQ-047 Reset-abort test: rst=0 in the second ACCESS cycle of a read -> no rsp_valid, all outputs at reset values next cycle, and a new request is accepted once rst=1.
